// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with bubble insertion, hold, flush and
// multi-cycle accumulate tracking for HI/LO multiply-accumulate.
module ex_mem_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ex_out_addr,
  input  logic [31:0] ex_out_data,
  input  logic        ex_out_en,
  input  logic        ex_hilo_wr_en,
  input  logic [31:0] ex_hi_data,
  input  logic [31:0] ex_lo_data,
  input  logic [63:0] ex_hilo_temp,
  input  logic [1:0]  ex_cnt,
  input  logic        stall_ex,
  input  logic        stall_mem,
  input  logic        flush,
  output logic [4:0]  mem_out_addr,
  output logic [31:0] mem_out_data,
  output logic        mem_out_en,
  output logic        mem_hilo_wr_en,
  output logic [31:0] mem_hi_data,
  output logic [31:0] mem_lo_data,
  output logic [63:0] hilo_temp_o,
  output logic [1:0]  cnt_o,
  output logic        acc_busy,
  output logic [15:0] bubble_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        en_q, en_d;
  logic        hwe_q, hwe_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [63:0] tmp_q, tmp_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] bub_q, bub_d;

  logic do_bubble;
  logic do_normal;

  assign do_bubble = stall_ex & ~stall_mem;
  assign do_normal = ~stall_ex & ~stall_mem;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    en_d    = en_q;
    hwe_d   = hwe_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    tmp_d   = tmp_q;
    cnt_d   = cnt_q;
    bub_d   = bub_q;
    if (flush) begin
      state_d = IDLE;
      addr_d  = '0;
      data_d  = '0;
      en_d    = 1'b0;
      hwe_d   = 1'b0;
      hi_d    = '0;
      lo_d    = '0;
      tmp_d   = '0;
      cnt_d   = '0;
    end else if (do_bubble) begin
      addr_d = '0;
      data_d = '0;
      en_d   = 1'b0;
      hwe_d  = 1'b0;
      hi_d   = '0;
      lo_d   = '0;
      if (bub_q != 16'hFFFF) bub_d = bub_q + 16'd1;
      if (ex_cnt != 2'd0) begin
        state_d = ACCUM;
        tmp_d   = ex_hilo_temp;
        cnt_d   = ex_cnt;
      end else if (state_q == ACCUM) begin
        // accumulate finished inside the stall window
        state_d = IDLE;
        tmp_d   = '0;
        cnt_d   = '0;
      end else begin
        tmp_d = ex_hilo_temp;
        cnt_d = ex_cnt;
      end
    end else if (do_normal) begin
      state_d = IDLE;
      addr_d  = ex_out_addr;
      data_d  = ex_out_data;
      en_d    = ex_out_en;
      hwe_d   = ex_hilo_wr_en;
      hi_d    = ex_hi_data;
      lo_d    = ex_lo_data;
      tmp_d   = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      en_q    <= 1'b0;
      hwe_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      tmp_q   <= '0;
      cnt_q   <= '0;
      bub_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      en_q    <= en_d;
      hwe_q   <= hwe_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      tmp_q   <= tmp_d;
      cnt_q   <= cnt_d;
      bub_q   <= bub_d;
    end
  end

  assign mem_out_addr   = addr_q;
  assign mem_out_data   = data_q;
  assign mem_out_en     = en_q;
  assign mem_hilo_wr_en = hwe_q;
  assign mem_hi_data    = hi_q;
  assign mem_lo_data    = lo_q;
  assign hilo_temp_o    = tmp_q;
  assign cnt_o          = cnt_q;
  assign acc_busy       = (state_q == ACCUM);
  assign bubble_cnt     = bub_q;

endmodule

// File: doc/ex_mem_reg.md
EX_MEM_REG -- requirements
Module: ex_mem_reg

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have ports ex_out_addr / ex_out_data / ex_out_en, input, 5/32/1, EX register-write address, data and enable.
REQ-004 SHALL have ports ex_hilo_wr_en / ex_hi_data / ex_lo_data, input, 1/32/32, EX HI/LO write request and values.
REQ-005 SHALL have ports ex_hilo_temp / ex_cnt, input, 64/2, EX partial multiply-accumulate result and step count.
REQ-006 SHALL have ports stall_ex / stall_mem / flush, input, 1 each, pipeline control from the stall controller.
REQ-007 SHALL have ports mem_out_addr / mem_out_data / mem_out_en, output, 5/32/1, registered register-write to MEM.
REQ-008 SHALL have ports mem_hilo_wr_en / mem_hi_data / mem_lo_data, output, 1/32/32, registered HI/LO write; also forwarded back to EX.
REQ-009 SHALL have ports hilo_temp_o / cnt_o, output, 64/2, held partial result and step count returned to EX.
REQ-010 SHALL have port acc_busy, output, 1, high while state is ACCUM.
REQ-011 SHALL have port bubble_cnt, output, 16, saturating count of bubbles inserted.

Function
REQ-012 All outputs SHALL be registered; latency EX->MEM exactly 1 cycle.
REQ-013 Priority per edge SHALL be: reset > flush > (stall_ex & stall_mem) > (stall_ex & !stall_mem) > normal.
REQ-014 Flush SHALL clear all MEM outputs, hilo_temp_o, cnt_o to 0 and force state IDLE; bubble_cnt unchanged.
REQ-015 Hold (stall_ex=1, stall_mem=1) SHALL keep every register, state and bubble_cnt unchanged.
REQ-016 Bubble (stall_ex=1, stall_mem=0) SHALL drive mem_out_en=0, mem_hilo_wr_en=0, addr/data/hi/lo=0 next cycle.
REQ-017 On bubble SHALL capture hilo_temp_o<=ex_hilo_temp, cnt_o<=ex_cnt.
REQ-018 On bubble SHALL increment bubble_cnt by 1, saturating at 16'hFFFF (no wrap).
REQ-019 Normal (stall_ex=0) SHALL load all MEM outputs from the EX inputs, clear hilo_temp_o and cnt_o to 0.
REQ-020 stall_mem=1 with stall_ex=0 is illegal; block SHALL treat it as hold (REQ-015).
REQ-021 State machine SHALL have two states, IDLE and ACCUM.
REQ-022 IDLE->ACCUM SHALL occur on a bubble edge with ex_cnt!=0.
REQ-023 ACCUM->IDLE SHALL occur on a normal edge or flush; ACCUM SHALL persist on hold and on bubbles.
REQ-024 In ACCUM, a bubble with ex_cnt=0 SHALL return state to IDLE and clear hilo_temp_o/cnt_o.
REQ-025 acc_busy SHALL equal (state==ACCUM), registered, no combinational path from inputs.
REQ-026 ex_cnt values 2'b11 SHALL be captured unmodified; block does no arithmetic on hilo data.

Reset
REQ-027 While reset=1 all outputs SHALL be 0 immediately (asynchronously), state IDLE, bubble_cnt 0.
REQ-028 Reset SHALL override any in-progress ACCUM or hold; first edge after deassertion follows REQ-013.

Verification
REQ-029 Normal: ex_out_addr=5'd3, ex_out_data=32'h1234_5678, ex_out_en=1 -> next edge mem_out_* equal those, cnt_o=0.
REQ-030 Bubble/accumulate: stall_ex=1, ex_cnt=1, ex_hilo_temp=64'h0000_0001_0000_0002 -> cnt_o=1, hilo_temp_o=that value, acc_busy=1, mem_out_en=0, bubble_cnt=1; release stall -> acc_busy=0, cnt_o=0.
REQ-031 Hold: load data 32'hA5A5_A5A5, then stall_ex=stall_mem=1 for 3 cycles -> outputs and bubble_cnt unchanged throughout.
REQ-032 Flush mid-ACCUM: enter ACCUM, assert flush with stall_ex=1 -> all outputs 0, acc_busy=0, bubble_cnt retained.
REQ-033 Saturation: force 65540 bubbles -> bubble_cnt stops at 16'hFFFF.
REQ-034 Async reset mid-cycle in ACCUM with mem_hilo_wr_en=1 -> outputs 0 before next clk edge, acc_busy=0.
